demux_fifo_n: RTL and testbench

Parametrised 1-to-N demultiplexer with a small FIFO on every output channel and a valid/ready handshake on both sides. It succeeds the 2-output, 8-bit registered demux: it adds arbitrary channel count and width, per-channel buffering, backpressure, and a round-robin distribution mode. It sits between a single byte-stream producer and N independent consumers, e.g. the lane splitter ahead of the parallel-to-serial stage.

---
 rtl/demux_fifo_n_pkg.sv | 15 +
 rtl/demux_fifo_n_if.sv | 34 +++
 rtl/demux_fifo_n_sync_fifo.sv | 61 ++++++
 rtl/demux_fifo_n.sv | 104 ++++++++++
 tb/tb_demux_fifo_n.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/demux_fifo_n_pkg.sv
// Shared constants and helpers for the 1-to-N demux with per-channel FIFOs.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

  // Distribution modes.
  localparam int MODE_SEL = 0;  // target comes from the sel input
  localparam int MODE_RR  = 1;  // target comes from the internal round-robin pointer

  // Low bit index of channel ch inside a flat bus of w-bit lanes.
  function automatic int chan_slice(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/demux_fifo_n_if.sv
// Producer/consumer bus of the 1-to-N demux: one input stream, N output lanes.
// Latency: n/a (wires only).
// Backpressure: ready_in toward the producer, per-lane pop from the consumers.
interface demux_fifo_n_if #(
  parameter int DATA_W = 8,
  parameter int NCH    = 4,
  parameter int SEL_W  = $clog2(NCH)
);
  // Producer side
  logic [DATA_W-1:0]     data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic [SEL_W-1:0]      sel;
  // Consumer side
  logic [NCH*DATA_W-1:0] data_out;
  logic [NCH-1:0]        valid_out;
  logic [NCH-1:0]        pop;
  logic [NCH-1:0]        full;
  // Status
  logic                  err_sel;
  logic [SEL_W-1:0]      rr_ptr;

  // Environment side: drives the stream and the pops.
  modport master (
    output data_in, valid_in, sel, pop,
    input  ready_in, data_out, valid_out, full, err_sel, rr_ptr
  );

  // Block side.
  modport slave (
    input  data_in, valid_in, sel, pop,
    output ready_in, data_out, valid_out, full, err_sel, rr_ptr
  );
endinterface

// File: rtl/demux_fifo_n_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word visible while non-empty, 0 when empty.
// Latency: 1 cycle from push to dout/!empty.
// Backpressure: push ignored when full (no bypass even with a same-cycle pop), pop ignored when empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_ok;
  logic              pop_ok;

  // Status comes straight from the registered count, so full/empty move on the same edge as the access.
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer/count state; reset wins over any access in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: stale entries are masked by the count.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/demux_fifo_n.sv
// 1-to-N demux steering a valid/ready byte stream into N FIFOs, by sel or round-robin.
// Latency: 1 cycle from accepted push to the word at the head of its lane.
// Backpressure: ready_in drops when the target lane is full; RR mode stalls rather than skipping a lane.
module demux_fifo_n
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCH    = 4,
  parameter int DEPTH  = 4,
  parameter int MODE   = MODE_SEL
) (
  input logic           clk,
  input logic           reset,
  demux_fifo_n_if.slave bus
);
  localparam int SEL_W = $clog2(NCH);
  localparam int TW    = SEL_W + 1;

  logic [SEL_W-1:0]      tgt;
  logic                  tgt_ok;
  logic                  full_t;
  logic                  ready;
  logic                  push;
  logic [NCH-1:0]        push_vec;
  logic [NCH-1:0]        fifo_full;
  logic [NCH-1:0]        fifo_empty;
  logic [NCH*DATA_W-1:0] dout_flat;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  err_sel_q, err_sel_d;

  // Target lane: explicit selector or the round-robin pointer; only sel can be out of range.
  always_comb begin
    tgt    = (MODE == MODE_RR) ? rr_ptr_q : bus.sel;
    tgt_ok = ({1'b0, tgt} < TW'(NCH));
  end

  // Full flag of the target lane; depends only on sel/rr_ptr and registered state, never on valid_in or pop.
  always_comb begin
    full_t = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (tgt == SEL_W'(i)) begin
        full_t = fifo_full[i];
      end
    end
  end

  // Handshake and push decode; an out-of-range word is accepted and dropped so the producer never hangs.
  always_comb begin
    ready    = !reset && (!tgt_ok || !full_t);
    push     = bus.valid_in && ready && tgt_ok;
    push_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      push_vec[i] = push && (tgt == SEL_W'(i));
    end
  end

  // Round-robin pointer moves only on a real push; sticky error on any valid out-of-range selector.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((MODE == MODE_RR) && push) begin
      rr_ptr_d = (rr_ptr_q == SEL_W'(NCH - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
    err_sel_d = err_sel_q;
    if ((MODE == MODE_SEL) && bus.valid_in && !tgt_ok) begin
      err_sel_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      err_sel_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      err_sel_q <= err_sel_d;
    end
  end

  // One FIFO per output lane; each lane pops independently.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_vec[i]),
      .pop   (bus.pop[i]),
      .din   (bus.data_in),
      .dout  (dout_flat[chan_slice(i, DATA_W) +: DATA_W]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i])
    );
  end

  assign bus.ready_in  = ready;
  assign bus.data_out  = dout_flat;
  assign bus.valid_out = ~fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.err_sel   = err_sel_q;
  assign bus.rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux_fifo_n.sv
// Three demux instances share one stimulus stream and are checked against a queue-based model.
// Instances: 0 = selector mode, 4 lanes; 1 = round-robin, 4 lanes; 2 = selector mode, 3 lanes.
module tb_demux_fifo_n;
  localparam int DEPTH = 4;
  localparam int NCH_A [3] = '{4, 4, 3};
  localparam int MODE_A[3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [1:0] sel;
  logic [3:0] pop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_fifo_n_if #(.DATA_W(8), .NCH(4)) if0 ();
  demux_fifo_n_if #(.DATA_W(8), .NCH(4)) if1 ();
  demux_fifo_n_if #(.DATA_W(8), .NCH(3)) if2 ();

  assign if0.data_in = data_in;  assign if0.valid_in = valid_in;
  assign if0.sel     = sel;      assign if0.pop      = pop;
  assign if1.data_in = data_in;  assign if1.valid_in = valid_in;
  assign if1.sel     = sel;      assign if1.pop      = pop;
  assign if2.data_in = data_in;  assign if2.valid_in = valid_in;
  assign if2.sel     = sel;      assign if2.pop      = pop[2:0];

  demux_fifo_n #(.DATA_W(8), .NCH(4), .DEPTH(DEPTH), .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  demux_fifo_n #(.DATA_W(8), .NCH(4), .DEPTH(DEPTH), .MODE(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  demux_fifo_n #(.DATA_W(8), .NCH(3), .DEPTH(DEPTH), .MODE(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

  // Uniform view of the three instances.
  logic [3:0] o_vld [3];
  logic [3:0] o_full[3];
  logic [7:0] o_dat [3][4];
  logic       o_rdy [3];
  logic       o_err [3];
  logic [1:0] o_rr  [3];

  assign o_vld[0]  = if0.valid_out;          assign o_vld[1]  = if1.valid_out;
  assign o_vld[2]  = {1'b0, if2.valid_out};
  assign o_full[0] = if0.full;               assign o_full[1] = if1.full;
  assign o_full[2] = {1'b0, if2.full};
  assign o_rdy[0]  = if0.ready_in;  assign o_rdy[1] = if1.ready_in;  assign o_rdy[2] = if2.ready_in;
  assign o_err[0]  = if0.err_sel;   assign o_err[1] = if1.err_sel;   assign o_err[2] = if2.err_sel;
  assign o_rr[0]   = if0.rr_ptr;    assign o_rr[1]  = if1.rr_ptr;    assign o_rr[2]  = if2.rr_ptr;

  for (genvar c = 0; c < 4; c++) begin : g_obs
    assign o_dat[0][c] = if0.data_out[c*8 +: 8];
    assign o_dat[1][c] = if1.data_out[c*8 +: 8];
    if (c < 3) begin : g_in
      assign o_dat[2][c] = if2.data_out[c*8 +: 8];
    end else begin : g_pad
      assign o_dat[2][c] = 8'h00;
    end
  end

  // Reference model: one queue per lane per instance, plus the pointer and error flag.
  logic [7:0] mq[3][4][$];
  int         mrr [3];
  bit         merr[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check ready_in before the edge, advance the model, check all outputs after it.
  task automatic step();
    bit       pu_a[3];
    int       tg_a[3];
    bit [3:0] po_a[3];
    int       tgt;
    bit       inr, rdy;
    #1;
    for (int k = 0; k < 3; k++) begin
      tgt = (MODE_A[k] == 1) ? mrr[k] : int'(sel);
      inr = tgt < NCH_A[k];
      rdy = !reset && (!inr || mq[k][tgt].size() < DEPTH);
      chk($sformatf("ready_in[%0d]", k), 32'(o_rdy[k]), 32'(rdy));
      pu_a[k] = valid_in && rdy && inr;
      tg_a[k] = tgt;
      for (int c = 0; c < 4; c++)
        po_a[k][c] = !reset && pop[c] && (c < NCH_A[k]) && (mq[k][c].size() > 0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int c = 0; c < 4; c++) mq[k][c].delete();
        mrr[k]  = 0;
        merr[k] = 0;
      end else begin
        for (int c = 0; c < 4; c++)
          if (po_a[k][c]) void'(mq[k][c].pop_front());
        if (pu_a[k]) begin
          mq[k][tg_a[k]].push_back(data_in);
          if (MODE_A[k] == 1) mrr[k] = (mrr[k] + 1) % NCH_A[k];
        end
        if (MODE_A[k] == 0 && valid_in && int'(sel) >= NCH_A[k]) merr[k] = 1;
      end
      for (int c = 0; c < NCH_A[k]; c++) begin
        chk($sformatf("valid_out[%0d][%0d]", k, c), 32'(o_vld[k][c]), 32'(mq[k][c].size() > 0));
        chk($sformatf("data_out[%0d][%0d]", k, c), 32'(o_dat[k][c]),
            (mq[k][c].size() > 0) ? 32'(mq[k][c][0]) : 32'h0);
        chk($sformatf("full[%0d][%0d]", k, c), 32'(o_full[k][c]), 32'(mq[k][c].size() == DEPTH));
      end
      chk($sformatf("err_sel[%0d]", k), 32'(o_err[k]), 32'(merr[k]));
      chk($sformatf("rr_ptr[%0d]", k), 32'(o_rr[k]), 32'(mrr[k]));
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; sel = 2'd0; pop = 4'h0; data_in = 8'h00;
    for (int k = 0; k < 3; k++) begin mrr[k] = 0; merr[k] = 0; end
    step(); step();
    reset = 1'b0;

    // Fill lane 2 in selector mode with A0..A3, no pops.
    sel = 2'd2; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin data_in = 8'hA0 + 8'(i); step(); end
    valid_in = 1'b0;
    step();
    chk("sel_full2", 32'(o_full[0][2]), 32'd1);
    chk("sel_ready_sel2", 32'(o_rdy[0]), 32'd0);
    chk("sel_head2", 32'(o_dat[0][2]), 32'hA0);
    chk("sel_others_empty", 32'({o_vld[0][3], o_vld[0][1], o_vld[0][0]}), 32'd0);

    // Round-robin: 0x10..0x17 land two per lane in order.
    reset = 1'b1; step(); reset = 1'b0;
    sel = 2'd0; valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin data_in = 8'h10 + 8'(i); step(); end
    valid_in = 1'b0;
    step();
    chk("rr_ptr_wrapped", 32'(o_rr[1]), 32'd0);
    chk("rr_all_valid", 32'(o_vld[1]), 32'hF);
    chk("rr_head0", 32'(o_dat[1][0]), 32'h10);
    chk("rr_head3", 32'(o_dat[1][3]), 32'h13);
    pop = 4'hF; step(); pop = 4'h0;
    chk("rr_second0", 32'(o_dat[1][0]), 32'h14);
    chk("rr_second3", 32'(o_dat[1][3]), 32'h17);
    pop = 4'hF; step(); pop = 4'h0;
    chk("rr_drained", 32'(o_vld[1]), 32'h0);

    // Steady push+pop on lane 1 at occupancy 2.
    reset = 1'b1; step(); reset = 1'b0;
    sel = 2'd1; valid_in = 1'b1;
    data_in = 8'h30; step();
    data_in = 8'h31; step();
    pop = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'h32 + 8'(i);
      step();
      chk("pp_no_full", 32'(o_full[0][1]), 32'd0);
      chk("pp_order", 32'(o_dat[0][1]), 32'h31 + 32'(i));
    end
    valid_in = 1'b0; pop = 4'h0;

    // Out-of-range selector on the 3-lane instance, then a pop on an empty lane.
    sel = 2'd3; valid_in = 1'b1; data_in = 8'hEE; step();
    valid_in = 1'b0; step();
    chk("oor_err", 32'(o_err[2]), 32'd1);
    chk("oor_lanes_unchanged", 32'(o_vld[2]), 32'b0010);
    pop = 4'b0001; step(); pop = 4'h0;
    chk("oor_err_sticky", 32'(o_err[2]), 32'd1);
    chk("empty_pop_ignored", 32'(o_vld[2]), 32'b0010);

    // One-cycle reset with lanes partly filled and rr_ptr at 2.
    reset = 1'b1; step(); reset = 1'b0;
    valid_in = 1'b1;
    sel = 2'd3; data_in = 8'h41; step();
    sel = 2'd0; data_in = 8'h42; step();
    valid_in = 1'b0;
    chk("pre_reset_rr", 32'(o_rr[1]), 32'd2);
    chk("pre_reset_err", 32'(o_err[2]), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(o_vld[k]), 32'h0);
      chk("rst_data0", 32'(o_dat[k][0]), 32'h0);
      chk("rst_rr", 32'(o_rr[k]), 32'd0);
      chk("rst_err", 32'(o_err[k]), 32'd0);
    end
    valid_in = 1'b1; sel = 2'd1; data_in = 8'h55; step();
    valid_in = 1'b0;
    chk("post_rst_sel", 32'(o_dat[0][1]), 32'h55);
    chk("post_rst_rr", 32'(o_dat[1][0]), 32'h55);

    // Round-robin stall on a full lane 1 until it is popped.
    reset = 1'b1; step(); reset = 1'b0;
    sel = 2'd0; valid_in = 1'b1;
    for (int i = 0; i < 18; i++) begin data_in = 8'h80 + 8'(i); step(); end
    chk("stall_at0", 32'(o_rdy[1]), 32'd0);
    pop = 4'b0001; step(); pop = 4'h0;
    step();
    chk("stall_rr1", 32'(o_rr[1]), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("stall_hold_rr", 32'(o_rr[1]), 32'd1);
    chk("stall_hold_ready", 32'(o_rdy[1]), 32'd0);
    pop = 4'b0010; step(); pop = 4'h0;
    chk("stall_after_pop_rr", 32'(o_rr[1]), 32'd1);
    chk("stall_after_pop_ready", 32'(o_rdy[1]), 32'd1);
    step();
    chk("stall_resumed_rr", 32'(o_rr[1]), 32'd2);
    valid_in = 1'b0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      reset    = ($urandom_range(0, 60) == 0);
      valid_in = 1'($urandom);
      sel      = 2'($urandom_range(0, 3));
      pop      = 4'($urandom) & 4'($urandom);
      data_in  = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
